cu_multicycle: RTL and testbench
================================

CU_MULTICYCLE -- requirements
Module: cu_multicycle

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum wait cycles for mem_ready per memory request; 0 disables the timeout.
REQ-002 SHALL have parameter TIMEOUT_W, default 4: width of the timeout counter; MEM_TIMEOUT SHALL be < 2**TIMEOUT_W.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- insn  in  32  current instruction-register contents.
- LU, LS, EQ  in  1 each  comparator flags: unsigned-less, signed-less, equal.
- mem_ready  in  1  memory completed the current request.
- mem_req, mem_we  out  1 each  memory request; write qualifier.
- pc_we, insn_we, rd_we  out  1 each  single-cycle write enables.
- addr_sel, pc_next_sel, pc_alu_sel, sub_sra, alu_sel_a, alu_sel_b  out  1 each  datapath selects.
- func  out  3  ALU function.
- rd_sel  out  2  writeback source.
- mem_size  out  2; mem_extend  out  3.
- rs1, rs2, rd  out  5 each.
- state  out  3  current FSM state.
- fault  out  1  sticky trap flag.

Function
REQ-004 SHALL decode fields combinationally: rs1=insn[19:15], rs2=insn[24:20], rd=insn[11:7], mem_size=insn[13:12], mem_extend=insn[14:12].
REQ-005 SHALL set func=insn[14:12] for R-type and I-ALU, else 000.
REQ-006 SHALL set sub_sra to: insn[30] for R-type; insn[30] for I-ALU only when funct3=101, otherwise 0; 1 for branches; 0 for all others.
REQ-007 SHALL set rd_sel to: 00 for load, 01 for LUI, 10 for ALU and AUIPC, 11 for JAL and JALR.
REQ-008 SHALL set alu_sel_a=1 for JAL and AUIPC only, and alu_sel_b=0 for R-type and branches only.
REQ-009 SHALL implement FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; state SHALL reflect the current state.
REQ-010 In FETCH: mem_req=1 and addr_sel=0; on mem_ready, insn_we=1 for that cycle and next state is DECODE.
REQ-011 In DECODE: an unsupported opcode, or a branch with funct3 010 or 011, SHALL go to TRAP; otherwise next state is EXEC.
REQ-012 In EXEC, branches: pc_we=1; pc_alu_sel=1 when taken, else 0; next state is FETCH.
- Taken conditions by funct3: 000 EQ, 001 !EQ, 100 LS, 101 !LS, 110 LU, 111 !LU.
REQ-013 In EXEC, other classes: loads and stores go to MEM; all remaining classes go to WB.
REQ-014 In MEM: mem_req=1 and addr_sel=1; mem_we=1 for stores.
- Store with mem_ready: pc_we=1 that cycle, next state FETCH.
- Load with mem_ready: next state WB.
REQ-015 In WB: rd_we=1 and pc_we=1 for exactly one cycle, with pc_next_sel=1 for JAL/JALR and 0 otherwise; next state is FETCH.
REQ-016 Enables SHALL be 0 in every state and cycle not listed above.
- Enables are pc_we, insn_we, rd_we, mem_req and mem_we.
REQ-017 Timeout counter:
- Clears on entry to FETCH or MEM.
- Increments each cycle mem_req=1 and mem_ready=0.
- When it reaches MEM_TIMEOUT with mem_ready=0, next state is TRAP.
- mem_ready arriving in the same cycle as the limit SHALL win.
REQ-018 TRAP: fault=1 and all enables 0; the FSM SHALL stay in TRAP until reset.
REQ-019 Latency with mem_ready constantly 1 SHALL be:
- 3 cycles for branches.
- 4 cycles for ALU, LUI, AUIPC, JAL, JALR and stores.
- 5 cycles for loads.

Reset
REQ-020 On reset=1 at a rising edge:
- state SHALL become FETCH.
- fault=0.
- Timeout counter=0.
- All enables 0 during reset.
REQ-021 Reset SHALL take priority over every transition, including mid-MEM with mem_req active and in TRAP.

Verification
REQ-022 addi x12,x1,12 (0x00C08613), mem_ready=1:
- Required: states 0,1,2,4; one cycle of rd_we=1 and pc_we=1 in WB; rd_sel=10; func=000; alu_sel_b=1.
REQ-023 beq x1,x2,8 (0x00208463):
- EQ=1: pc_we=1 and pc_alu_sel=1 in EXEC, return to FETCH after 3 cycles.
- EQ=0: pc_alu_sel=0.
REQ-024 lb x7,4(x4) (0x00420383), mem_ready held low 3 cycles in MEM:
- Required: mem_req=1 and addr_sel=1 for 4 cycles, then WB with rd_sel=00 and mem_extend=000.
REQ-025 sh x5,12(x4) (0x00521623), mem_ready never asserted, MEM_TIMEOUT=15:
- Required: TRAP after 15 wait cycles; fault=1 and stays 1; reset returns to FETCH with fault=0.
REQ-026 Invalid insn 0x0000007F in DECODE -> TRAP with no enable pulsed.
REQ-027 Reset asserted while in MEM:
- Required: next cycle state=0, mem_req=1 (FETCH), mem_we=0.

Source files
------------

// File: rtl/cu_multicycle.sv
// Multicycle RISC-V control unit: fetch/decode/execute/memory/writeback FSM with
// combinational field decode, a per-request memory timeout and a sticky trap state.
module cu_multicycle #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TIMEOUT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] insn,
  input  logic        LU,
  input  logic        LS,
  input  logic        EQ,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        pc_we,
  output logic        insn_we,
  output logic        rd_we,
  output logic        addr_sel,
  output logic        pc_next_sel,
  output logic        pc_alu_sel,
  output logic        sub_sra,
  output logic        alu_sel_a,
  output logic        alu_sel_b,
  output logic [2:0]  func,
  output logic [1:0]  rd_sel,
  output logic [1:0]  mem_size,
  output logic [2:0]  mem_extend,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  state,
  output logic        fault
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpAluI   = 7'b0010011;
  localparam logic [6:0] OpAluR   = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [TIMEOUT_W:0]   cnt_inc;
  logic                 timeout_hit;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic is_r, is_i, is_load, is_store, is_branch, is_lui, is_auipc, is_jal, is_jalr;
  logic valid_op, bad_branch, taken;
  logic mem_req_c, mem_we_c, pc_we_c, insn_we_c, rd_we_c;
  logic unused_insn;

  assign opcode    = insn[6:0];
  assign funct3    = insn[14:12];
  assign is_r      = (opcode == OpAluR);
  assign is_i      = (opcode == OpAluI);
  assign is_load   = (opcode == OpLoad);
  assign is_store  = (opcode == OpStore);
  assign is_branch = (opcode == OpBranch);
  assign is_lui    = (opcode == OpLui);
  assign is_auipc  = (opcode == OpAuipc);
  assign is_jal    = (opcode == OpJal);
  assign is_jalr   = (opcode == OpJalr);
  assign valid_op  = is_r | is_i | is_load | is_store | is_branch | is_lui | is_auipc |
                     is_jal | is_jalr;
  assign bad_branch = is_branch && (funct3 == 3'b010 || funct3 == 3'b011);
  assign unused_insn = ^{insn[31], insn[29:25]};

  assign rs1        = insn[19:15];
  assign rs2        = insn[24:20];
  assign rd         = insn[11:7];
  assign mem_size   = insn[13:12];
  assign mem_extend = insn[14:12];
  assign func       = (is_r || is_i) ? funct3 : 3'b000;
  assign sub_sra    = is_r ? insn[30] :
                      is_i ? (funct3 == 3'b101 && insn[30]) : is_branch;
  assign rd_sel     = is_load ? 2'b00 : is_lui ? 2'b01 : (is_jal || is_jalr) ? 2'b11 : 2'b10;
  assign alu_sel_a  = is_jal | is_auipc;
  assign alu_sel_b  = ~(is_r | is_branch);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = EQ;
      3'b001:  taken = ~EQ;
      3'b100:  taken = LS;
      3'b101:  taken = ~LS;
      3'b110:  taken = LU;
      3'b111:  taken = ~LU;
      default: taken = 1'b0;
    endcase
  end

  // Limit is reached on the wait cycle that would bring the count up to MEM_TIMEOUT.
  assign cnt_inc     = {1'b0, cnt_q} + (TIMEOUT_W + 1)'(1);
  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_inc == (TIMEOUT_W + 1)'(MEM_TIMEOUT));

  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    pc_we_c     = 1'b0;
    insn_we_c   = 1'b0;
    rd_we_c     = 1'b0;
    addr_sel    = 1'b0;
    pc_alu_sel  = 1'b0;
    pc_next_sel = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          insn_we_c = 1'b1;
          state_d   = StDecode;
        end else if (timeout_hit) begin
          state_d = StTrap;
        end
      end
      StDecode: state_d = (!valid_op || bad_branch) ? StTrap : StExec;
      StExec: begin
        if (is_branch) begin
          pc_we_c    = 1'b1;
          pc_alu_sel = taken;
          state_d    = StFetch;
        end else if (is_load || is_store) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        mem_req_c = 1'b1;
        addr_sel  = 1'b1;
        mem_we_c  = is_store;
        if (mem_ready) begin
          pc_we_c = is_store;
          state_d = is_store ? StFetch : StWb;
        end else if (timeout_hit) begin
          state_d = StTrap;
        end
      end
      StWb: begin
        rd_we_c     = 1'b1;
        pc_we_c     = 1'b1;
        pc_next_sel = is_jal | is_jalr;
        state_d     = StFetch;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase

    cnt_d = cnt_q;
    if ((state_d == StFetch || state_d == StMem) && state_d != state_q) begin
      cnt_d = '0;
    end else if (mem_req_c && !mem_ready) begin
      cnt_d = cnt_inc[TIMEOUT_W-1:0];
    end
  end

  // Reset forces every enable low in the same cycle, even mid-request.
  assign mem_req = mem_req_c & ~reset;
  assign mem_we  = mem_we_c & ~reset;
  assign pc_we   = pc_we_c & ~reset;
  assign insn_we = insn_we_c & ~reset;
  assign rd_we   = rd_we_c & ~reset;
  assign state   = state_q;
  assign fault   = (state_q == StTrap);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cu_multicycle.sv
// Scoreboard bench for cu_multicycle: stimulus queues the expected per-cycle response,
// a negedge monitor pops and compares it against the DUT.
module tb_cu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] insn;
  logic        LU, LS, EQ, mem_ready;
  logic        mem_req, mem_we, pc_we, insn_we, rd_we;
  logic        addr_sel, pc_next_sel, pc_alu_sel, sub_sra, alu_sel_a, alu_sel_b;
  logic [2:0]  func;
  logic [1:0]  rd_sel, mem_size;
  logic [2:0]  mem_extend;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  state;
  logic        fault;

  cu_multicycle dut (
    .clk        (clk),
    .reset      (reset),
    .insn       (insn),
    .LU         (LU),
    .LS         (LS),
    .EQ         (EQ),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .pc_we      (pc_we),
    .insn_we    (insn_we),
    .rd_we      (rd_we),
    .addr_sel   (addr_sel),
    .pc_next_sel(pc_next_sel),
    .pc_alu_sel (pc_alu_sel),
    .sub_sra    (sub_sra),
    .alu_sel_a  (alu_sel_a),
    .alu_sel_b  (alu_sel_b),
    .func       (func),
    .rd_sel     (rd_sel),
    .mem_size   (mem_size),
    .mem_extend (mem_extend),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .state      (state),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          id;
    logic [2:0]  st;
    logic [4:0]  en;
    logic        flt;
    logic [13:0] sel;
    logic [13:0] msk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  // Enable order {pc_we, insn_we, rd_we, mem_req, mem_we}
  localparam logic [4:0] EnNone  = 5'b00000;
  localparam logic [4:0] EnFetch = 5'b01010;
  localparam logic [4:0] EnWait  = 5'b00010;
  localparam logic [4:0] EnWb    = 5'b10100;
  localparam logic [4:0] EnBr    = 5'b10000;
  localparam logic [4:0] EnStW   = 5'b00011;
  localparam logic [4:0] EnStD   = 5'b10011;
  localparam logic [13:0] MAll   = 14'h3FFF;
  localparam logic [13:0] MNoRd  = 14'h3FE7;
  localparam logic [13:0] MNone  = 14'h0000;

  function automatic logic [13:0] mk_sel(input logic as, input logic pca, input logic pcn,
                                         input logic ss, input logic a, input logic b,
                                         input logic [2:0] fn, input logic [1:0] rs,
                                         input logic [2:0] ext);
    return {as, pca, pcn, ss, a, b, fn, rs, ext};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: compares the DUT against the oldest queued expectation each cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check($sformatf("state@%0d", e.id), {29'd0, state}, {29'd0, e.st});
      check($sformatf("enables@%0d", e.id), {27'd0, pc_we, insn_we, rd_we, mem_req, mem_we},
            {27'd0, e.en});
      check($sformatf("fault@%0d", e.id), {31'd0, fault}, {31'd0, e.flt});
      if (e.msk != 14'd0)
        check($sformatf("selects@%0d", e.id),
              {18'd0, {addr_sel, pc_alu_sel, pc_next_sel, sub_sra, alu_sel_a, alu_sel_b,
                       func, rd_sel, mem_extend} & e.msk}, {18'd0, e.sel & e.msk});
    end
  end

  task automatic cyc(input logic rdy, input logic rst, input logic [2:0] st, input logic [4:0] en,
                     input logic flt, input logic [13:0] sel, input logic [13:0] msk);
    exp_t e;
    mem_ready = rdy;
    reset     = rst;
    e = '{id: step, st: st, en: en, flt: flt, sel: sel, msk: msk};
    exp_q.push_back(e);
    step++;
    @(posedge clk);
    #1;
  endtask

  // Plain 4-cycle instruction (ALU/LUI/AUIPC/JAL) with mem_ready high.
  task automatic run_wb(input logic [31:0] i, input logic [13:0] s, input logic [13:0] swb);
    insn = i;
    cyc(1'b1, 1'b0, 3'd0, EnFetch, 1'b0, s, MAll);
    cyc(1'b1, 1'b0, 3'd1, EnNone, 1'b0, s, MAll);
    cyc(1'b1, 1'b0, 3'd2, EnNone, 1'b0, s, MAll);
    cyc(1'b1, 1'b0, 3'd4, EnWb, 1'b0, swb, MAll);
  endtask

  task automatic run_br(input logic [31:0] i, input logic [2:0] f3, input logic tk);
    logic [13:0] s;
    s = mk_sel(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00, f3);
    insn = i;
    cyc(1'b1, 1'b0, 3'd0, EnFetch, 1'b0, s, MNoRd);
    cyc(1'b1, 1'b0, 3'd1, EnNone, 1'b0, s, MNoRd);
    cyc(1'b1, 1'b0, 3'd2, EnBr, 1'b0, s | {1'b0, tk, 12'd0}, MNoRd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] s_addi, s_lb, s_lbm, s_sh, s_shm, s_jal;
    s_addi = mk_sel(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 2'b10, 3'b000);
    s_lb   = mk_sel(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 3'b000);
    s_lbm  = s_lb | 14'h2000;
    s_sh   = mk_sel(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 3'b001);
    s_shm  = s_sh | 14'h2000;
    s_jal  = mk_sel(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 2'b11, 3'b000);

    reset = 1'b1; mem_ready = 1'b0; insn = 32'h00C08613;
    EQ = 1'b0; LS = 1'b0; LU = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Post-reset FETCH with a stalled fetch, then addi x12,x1,12
    cyc(1'b0, 1'b0, 3'd0, EnWait, 1'b0, s_addi, MAll);
    check("addi.rs1", {27'd0, rs1}, 32'd1);
    check("addi.rs2", {27'd0, rs2}, 32'd12);
    check("addi.rd", {27'd0, rd}, 32'd12);
    run_wb(32'h00C08613, s_addi, s_addi);

    run_wb(32'h402081B3, mk_sel(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 2'b10, 3'b000),
           mk_sel(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 2'b10, 3'b000));
    run_wb(32'h4030D093, mk_sel(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b101, 2'b10, 3'b101),
           mk_sel(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b101, 2'b10, 3'b101));
    run_wb(32'h123452B7, mk_sel(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 2'b01, 3'b101),
           mk_sel(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 2'b01, 3'b101));
    run_wb(32'h000000EF, s_jal, s_jal | 14'h0800);

    EQ = 1'b1; run_br(32'h00208463, 3'b000, 1'b1);
    EQ = 1'b0; run_br(32'h00208463, 3'b000, 1'b0);
    LS = 1'b1; run_br(32'h0020C463, 3'b100, 1'b1);
    LU = 1'b1; run_br(32'h0020F463, 3'b111, 1'b0);
    LS = 1'b0; LU = 1'b0;

    // lb x7,4(x4) with three stalled memory cycles
    insn = 32'h00420383;
    check("lb.rd", {27'd0, rd}, 32'd7);
    check("lb.rs1", {27'd0, rs1}, 32'd4);
    cyc(1'b1, 1'b0, 3'd0, EnFetch, 1'b0, s_lb, MAll);
    cyc(1'b1, 1'b0, 3'd1, EnNone, 1'b0, s_lb, MAll);
    cyc(1'b1, 1'b0, 3'd2, EnNone, 1'b0, s_lb, MAll);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 3'd3, EnWait, 1'b0, s_lbm, MAll);
    cyc(1'b1, 1'b0, 3'd3, EnWait, 1'b0, s_lbm, MAll);
    cyc(1'b1, 1'b0, 3'd4, EnWb, 1'b0, s_lb, MAll);

    // sh x5,12(x4) completing immediately
    insn = 32'h00521623;
    check("sh.rs2", {27'd0, rs2}, 32'd5);
    check("sh.mem_size", {30'd0, mem_size}, 32'd1);
    cyc(1'b1, 1'b0, 3'd0, EnFetch, 1'b0, s_sh, MNoRd);
    cyc(1'b1, 1'b0, 3'd1, EnNone, 1'b0, s_sh, MNoRd);
    cyc(1'b1, 1'b0, 3'd2, EnNone, 1'b0, s_sh, MNoRd);
    cyc(1'b1, 1'b0, 3'd3, EnStD, 1'b0, s_shm, MNoRd);

    // Reset while the store waits in MEM, then the store replays
    cyc(1'b1, 1'b0, 3'd0, EnFetch, 1'b0, s_sh, MNoRd);
    cyc(1'b1, 1'b0, 3'd1, EnNone, 1'b0, s_sh, MNoRd);
    cyc(1'b1, 1'b0, 3'd2, EnNone, 1'b0, s_sh, MNoRd);
    cyc(1'b0, 1'b1, 3'd3, EnNone, 1'b0, s_shm, MNoRd);
    cyc(1'b1, 1'b0, 3'd0, EnFetch, 1'b0, s_sh, MNoRd);
    cyc(1'b1, 1'b0, 3'd1, EnNone, 1'b0, s_sh, MNoRd);
    cyc(1'b1, 1'b0, 3'd2, EnNone, 1'b0, s_sh, MNoRd);
    cyc(1'b1, 1'b0, 3'd3, EnStD, 1'b0, s_shm, MNoRd);

    // Store that never completes: 15 wait cycles then sticky TRAP
    cyc(1'b1, 1'b0, 3'd0, EnFetch, 1'b0, s_sh, MNoRd);
    cyc(1'b1, 1'b0, 3'd1, EnNone, 1'b0, s_sh, MNoRd);
    cyc(1'b1, 1'b0, 3'd2, EnNone, 1'b0, s_sh, MNoRd);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 3'd3, EnStW, 1'b0, s_shm, MNoRd);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 3'd5, EnNone, 1'b1, s_sh, MNone);
    cyc(1'b0, 1'b1, 3'd5, EnNone, 1'b1, s_sh, MNone);
    cyc(1'b0, 1'b0, 3'd0, EnWait, 1'b0, s_sh, MNoRd);

    // Unsupported opcode traps from DECODE with no enable
    insn = 32'h0000007F;
    cyc(1'b1, 1'b0, 3'd0, EnFetch, 1'b0, 14'd0, MNone);
    cyc(1'b1, 1'b0, 3'd1, EnNone, 1'b0, 14'd0, MNone);
    cyc(1'b1, 1'b0, 3'd5, EnNone, 1'b1, 14'd0, MNone);
    cyc(1'b1, 1'b0, 3'd5, EnNone, 1'b1, 14'd0, MNone);
    cyc(1'b0, 1'b1, 3'd5, EnNone, 1'b1, 14'd0, MNone);
    cyc(1'b0, 1'b0, 3'd0, EnWait, 1'b0, 14'd0, MNone);

    // Branch with reserved funct3 traps too
    insn = 32'h0020A463;
    cyc(1'b1, 1'b0, 3'd0, EnFetch, 1'b0, 14'd0, MNone);
    cyc(1'b1, 1'b0, 3'd1, EnNone, 1'b0, 14'd0, MNone);
    cyc(1'b1, 1'b0, 3'd5, EnNone, 1'b1, 14'd0, MNone);

    @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
